nfc_t_counter_mc: RTL and testbench

//  Parametrised multi-channel terminal counter; successor to the single 3-bit timing counter in the NFC datapath.

---
 rtl/nfc_t_counter_mc.sv | 115 +++++++++++
 tb/tb_nfc_t_counter_mc.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/nfc_t_counter_mc.sv
// nfc_t_counter_mc -- multi-channel terminal counter for the NFC framing/timing FSMs.
// NUM_CH independent WIDTH-bit counters, each with its own enable, terminal value and
// mode (0 = auto-reload, 1 = one-shot). Each channel gives a one-cycle terminal pulse
// (t_tc) and a one-shot done level (t_done). All outputs come straight from flops.
// Optional build macro TCNT_PRESCALE_EN adds the pre_div port and a shared PRE_W-bit
// prescaler that gates the count tick; without it every cycle is a tick.
module nfc_t_counter_mc #(
   parameter int unsigned WIDTH  = 3,
   parameter int unsigned NUM_CH = 1,
   parameter int unsigned PRE_W  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       t_en,
   input  logic [NUM_CH-1:0]       t_mode,
   input  logic [NUM_CH*WIDTH-1:0] tconf_c,
`ifdef TCNT_PRESCALE_EN
   input  logic [PRE_W-1:0]        pre_div,
`endif
   output logic [NUM_CH*WIDTH-1:0] t_cnt,
   output logic [NUM_CH-1:0]       t_tc,
   output logic [NUM_CH-1:0]       t_done
);

   // Shared count strobe for all channels.
   logic tick;

`ifdef TCNT_PRESCALE_EN
   logic [PRE_W-1:0] pre_q, pre_d;

   // Prescaler: strobe when the count reaches (or passes, after a divisor change) pre_div.
   // Using >= keeps a lowered divisor from making the prescaler wrap through 2^PRE_W.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      tick  = (pre_q >= pre_div);
      pre_d = pre_q;
      if (t_en == '0) begin
         pre_d = '0;
      end else if (tick) begin
         pre_d = '0;
      end else begin
         pre_d = pre_q + PRE_W'(1);
      end
   end

   // Prescaler state register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_n) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end
`else
   // No prescaler: every cycle is a tick. PRE_W has no effect in this build; it is folded
   // into a constant-true term only so the parameter is referenced.
   assign tick = 1'b1 | (PRE_W == 0);
`endif

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [WIDTH-1:0] tconf;
      logic [WIDTH-1:0] cnt_q, cnt_d;
      logic             tc_q, tc_d;
      logic             done_q, done_d;

      assign tconf = tconf_c[g*WIDTH +: WIDTH];

      // Next-state for one channel: disable clears, no tick holds, terminal reloads or
      // latches done, otherwise count up. Terminal is an unsigned >= so lowering tconf
      // below the running count terminates on the next tick instead of wrapping.
      always_comb begin
         cnt_d  = cnt_q;
         tc_d   = 1'b0;
         done_d = done_q;
         if (!t_en[g]) begin
            cnt_d  = '0;
            done_d = 1'b0;
         end else if (tick) begin
            if (cnt_q >= tconf) begin
               if (!t_mode[g]) begin
                  // Auto-reload; a done level left from an earlier one-shot run
                  // is kept until the channel is disabled.
                  cnt_d = '0;
                  tc_d  = 1'b1;
               end else if (!done_q) begin
                  tc_d   = 1'b1;
                  done_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + WIDTH'(1);
            end
         end
      end

      // Channel state registers; these flops drive the outputs directly.
      always_ff @(posedge clk or negedge rst_n) begin
         // NOTE: only control/state flops exist here, so all of them take the async reset.
         if (!rst_n) begin
            cnt_q  <= '0;
            tc_q   <= 1'b0;
            done_q <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            tc_q   <= tc_d;
            done_q <= done_d;
         end
      end

      assign t_cnt[g*WIDTH +: WIDTH] = cnt_q;
      assign t_tc[g]                 = tc_q;
      assign t_done[g]               = done_q;
   end

endmodule

// File: tb/tb_nfc_t_counter_mc.sv
// Bench for nfc_t_counter_mc, WIDTH=3, NUM_CH=3. Inputs change on the falling edge,
// the expected post-edge state is queued at that moment and popped/compared 1 ns after
// the rising edge. Single-channel corner cases come from a vector table; the
// multi-channel and prescaler sections compute expectations from closed-form periods.
module tb_nfc_t_counter_mc;
   localparam int W = 3;
   localparam int N = 3;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   t_en;
   logic [N-1:0]   t_mode;
   logic [N*W-1:0] tconf_c;
   logic [N*W-1:0] t_cnt;
   logic [N-1:0]   t_tc;
   logic [N-1:0]   t_done;
`ifdef TCNT_PRESCALE_EN
   logic [3:0]     pre_div;
`endif

   nfc_t_counter_mc #(.WIDTH(W), .NUM_CH(N), .PRE_W(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .t_en    (t_en),
      .t_mode  (t_mode),
      .tconf_c (tconf_c),
`ifdef TCNT_PRESCALE_EN
      .pre_div (pre_div),
`endif
      .t_cnt   (t_cnt),
      .t_tc    (t_tc),
      .t_done  (t_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [N*W-1:0] cnt;
      logic [N-1:0]   tc;
      logic [N-1:0]   done;
   } exp_t;

   typedef struct packed {
      logic [N-1:0]   en;
      logic [N-1:0]   mode;
      logic [N*W-1:0] tconf;
      exp_t           exp;
   } vec_t;

   vec_t  vecs[$];
   exp_t  sb_q[$];
   string tag_q[$];
   int    checks   = 0;
   int    failures = 0;

   function automatic exp_t mk(input logic [N*W-1:0] cnt, input logic [N-1:0] tc,
                               input logic [N-1:0] done);
      exp_t e;
      e.cnt  = cnt;
      e.tc   = tc;
      e.done = done;
      return e;
   endfunction

   task automatic check(input string tag, input exp_t got, input exp_t want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got cnt=%h tc=%b done=%b, expected cnt=%h tc=%b done=%b",
                  tag, got.cnt, got.tc, got.done, want.cnt, want.tc, want.done);
      end
   endtask

   // Drive one cycle of stimulus, queue its expected result, compare after the edge.
   task automatic step(input logic [N-1:0] en, input logic [N-1:0] mode,
                       input logic [N*W-1:0] tconf, input exp_t e, input string tag);
      exp_t  want;
      string t;
      @(negedge clk);
      t_en    = en;
      t_mode  = mode;
      tconf_c = tconf;
      sb_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      want = sb_q.pop_front();
      t    = tag_q.pop_front();
      check(t, mk(t_cnt, t_tc, t_done), want);
   endtask

   // Table entry exercising channel 0 only; channels 1 and 2 stay disabled at zero.
   task automatic add0(input bit en, input bit mode, input int tconf, input int cnt,
                       input bit tc, input bit done);
      vec_t v;
      v.en       = {2'b00, en};
      v.mode     = {2'b00, mode};
      v.tconf    = {6'd0, 3'(tconf)};
      v.exp.cnt  = {6'd0, 3'(cnt)};
      v.exp.tc   = {2'b00, tc};
      v.exp.done = {2'b00, done};
      vecs.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int k[N];
      int p[N];
      exp_t e;

      // auto-reload, tconf=4: period 5
      add0(1,0,4, 1,0,0); add0(1,0,4, 2,0,0); add0(1,0,4, 3,0,0); add0(1,0,4, 4,0,0);
      add0(1,0,4, 0,1,0); add0(1,0,4, 1,0,0); add0(1,0,4, 2,0,0); add0(1,0,4, 3,0,0);
      add0(1,0,4, 4,0,0); add0(1,0,4, 0,1,0); add0(0,0,4, 0,0,0);
      // one-shot, tconf=3: hold at 3, one tc pulse, done stays until disable
      add0(1,1,3, 1,0,0); add0(1,1,3, 2,0,0); add0(1,1,3, 3,0,0); add0(1,1,3, 3,1,1);
      add0(1,1,3, 3,0,1); add0(1,1,3, 3,0,1); add0(0,1,3, 0,0,0);
      // tconf=0: auto pulses every cycle, one-shot done on first edge
      add0(1,0,0, 0,1,0); add0(1,0,0, 0,1,0); add0(1,0,0, 0,1,0); add0(0,0,0, 0,0,0);
      add0(1,1,0, 0,1,1); add0(1,1,0, 0,0,1); add0(0,1,0, 0,0,0);
      // tconf=7: reaches max then reloads, no overflow
      add0(1,0,7, 1,0,0); add0(1,0,7, 2,0,0); add0(1,0,7, 3,0,0); add0(1,0,7, 4,0,0);
      add0(1,0,7, 5,0,0); add0(1,0,7, 6,0,0); add0(1,0,7, 7,0,0); add0(1,0,7, 0,1,0);
      add0(1,0,7, 1,0,0); add0(0,0,7, 0,0,0);
      // tconf lowered 6 -> 2 while cnt=5: terminal on next tick, no wrap
      add0(1,0,6, 1,0,0); add0(1,0,6, 2,0,0); add0(1,0,6, 3,0,0); add0(1,0,6, 4,0,0);
      add0(1,0,6, 5,0,0); add0(1,0,2, 0,1,0); add0(1,0,2, 1,0,0); add0(1,0,2, 2,0,0);
      add0(1,0,2, 0,1,0); add0(0,0,2, 0,0,0);

      rst_n   = 1'b0;
      t_en    = '0;
      t_mode  = '0;
      tconf_c = '0;
`ifdef TCNT_PRESCALE_EN
      pre_div = '0;
`endif
      #12;
      check("reset_state", mk(t_cnt, t_tc, t_done), mk('0, '0, '0));
      @(negedge clk);
      rst_n = 1'b1;

      // Async reset mid-count at cnt=5.
      for (int n = 1; n <= 5; n++)
         step(3'b001, 3'b000, 9'd7, mk(9'(n), 3'b000, 3'b000), $sformatf("t1_count%0d", n));
      #2;
      rst_n = 1'b0;
      #1;
      check("t1_async_reset", mk(t_cnt, t_tc, t_done), mk('0, '0, '0));
      t_en = '0;
      @(negedge clk);
      rst_n = 1'b1;
      step(3'b000, 3'b000, 9'd7, mk('0, '0, '0), "t1_after_release");

      // Vector table.
      for (int i = 0; i < vecs.size(); i++)
         step(vecs[i].en, vecs[i].mode, vecs[i].tconf, vecs[i].exp, $sformatf("vec%0d", i));

      // Multi-channel: tconf 2,3,5 auto; ch1 off for cycles 24..35, then back on.
      p[0] = 3; p[1] = 4; p[2] = 6;
      for (int i = 0; i < N; i++) k[i] = 0;
      for (int n = 0; n < 48; n++) begin
         logic [N-1:0] en;
         en = (n >= 24 && n < 36) ? 3'b101 : 3'b111;
         for (int i = 0; i < N; i++) begin
            k[i] = en[i] ? k[i] + 1 : 0;
            e.cnt[i*W +: W] = W'(k[i] % p[i]);
            e.tc[i]         = (k[i] != 0) && (k[i] % p[i] == 0);
            e.done[i]       = 1'b0;
         end
         step(en, 3'b000, {3'd5, 3'd3, 3'd2}, e, $sformatf("multi%0d", n));
      end
      step(3'b000, 3'b000, {3'd5, 3'd3, 3'd2}, mk('0, '0, '0), "multi_off");

`ifdef TCNT_PRESCALE_EN
      // Prescaler divide-by-3, tconf=1: cnt steps every 3 cycles, tc every 6.
      pre_div = 4'd2;
      for (int n = 1; n <= 12; n++) begin
         int ticks;
         ticks = n / 3;
         e = mk({6'd0, 3'(ticks % 2)},
                {2'b00, (n % 3 == 0) && (ticks % 2 == 0)}, '0);
         step(3'b001, 3'b000, 9'd1, e, $sformatf("pre%0d", n));
      end
      step(3'b000, 3'b000, 9'd1, mk('0, '0, '0), "pre_off");
`endif

      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
